// File: rtl/muldiv_hilo_ctrl.sv
// Sequencer for the iterative shift-add multiplier plus the HI/LO register pair.
// Latches operands, strobes the load, counts iterations and captures the product.
module muldiv_hilo_ctrl #(
  parameter int W    = 32,
  parameter int ITER = 32,
  parameter int CW   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] srcA_in,
  input  logic [W-1:0] srcB_in,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  output logic         multCtrl,
  output logic [W-1:0] mult_srcA,
  output logic [W-1:0] mult_srcB,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WRITE} state_t;

  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  opA, opB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operands only latch from IDLE, so stray starts mid-operation cannot disturb them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      opA  <= '0;
      opB  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == WRITE);
      if (state == IDLE && start) begin
        opA <= srcA_in;
        opB <= srcB_in;
      end
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      if (state == WRITE) begin
        hi <= mult_hi;
        lo <= mult_lo;
      end else if (state == IDLE) begin
        if (mthi) hi <= wr_data;
        if (mtlo) lo <= wr_data;
      end
    end
  end

  assign multCtrl  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign mult_srcA = opA;
  assign mult_srcB = opB;

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Sequencing controller and HI/LO architectural register pair for the iterative shift-add multiplier.
- Accepts a multiply request from the execute stage and latches the operands.
- Pulses the multiplier's load control for one cycle, then counts the iteration cycles.
- Captures the 64-bit product into HI/LO and raises busy for the pipeline stall logic.
- Also services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.

Parameters:
- W, 32, operand and HI/LO width.
- ITER, 32, multiplier iteration cycles after load (W for the shift-add unit).
- CW, 6, counter width (must satisfy 2^CW > ITER).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  multiply request, single-cycle pulse from execute stage.
- srcA_in  in  W  multiplicand.
- srcB_in  in  W  multiplier.
- mthi  in  1  write wr_data into HI.
- mtlo  in  1  write wr_data into LO.
- wr_data  in  W  data for MTHI/MTLO.
- mult_hi  in  W  product upper word from multiplier.
- mult_lo  in  W  product lower word from multiplier.
- multCtrl  out  1  multiplier load strobe.
- mult_srcA  out  W  held operand A to multiplier.
- mult_srcB  out  W  held operand B to multiplier.
- busy  out  1  operation in flight; the pipeline stalls on it.
- done  out  1  one-cycle pulse, HI/LO freshly written by a multiply.
- hi  out  W  HI register.
- lo  out  W  LO register.

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, opA/opB=0, hi=lo=0, done=0, multCtrl=0, busy=0. Reset mid-operation abandons the operation; no HI/LO update occurs.
- Multiplier contract:
  - On the edge where multCtrl=1, the multiplier loads its operands.
  - Each subsequent edge with multCtrl=0 performs one iteration.
  - mult_hi/mult_lo hold the signed 64-bit product after ITER iterations.
  - The multiplier keeps iterating while this block is idle; this is harmless because results are only captured in WRITE.
- State machine (IDLE, LOAD, RUN, WRITE):
  - IDLE: when start=1, latch opA<=srcA_in and opB<=srcB_in, then go to LOAD. Otherwise stay.
  - LOAD: multCtrl=1 (decoded from state, 1 cycle). Next state RUN, cnt<=0.
  - RUN: multCtrl=0, cnt increments every edge. When cnt==ITER-1, go to WRITE.
  - WRITE: on the edge leaving WRITE, hi<=mult_hi, lo<=mult_lo, done<=1, state<=IDLE.
- Outputs:
  - mult_srcA=opA and mult_srcB=opB, held stable from LOAD through WRITE.
  - busy = (state!=IDLE), combinational from the state register.
  - done is registered and high for exactly one cycle after WRITE; otherwise 0.
- Latency, with start sampled at edge E0:
  - LOAD during E0..E1.
  - Iterations at E2..E(ITER+1).
  - HI/LO updated at E(ITER+2), i.e. E34 for defaults.
  - done high during E34..E35.
  - busy high during E0..E34 (after E0, before E34).
- Back-to-back: a start sampled in the cycle done is high is accepted normally. Minimum issue interval is ITER+3 cycles.
- start while busy: ignored (no latch, no restart). The pipeline must not issue one.
- MTHI/MTLO:
  - Honoured only in IDLE; hi/lo update on the next edge.
  - Ignored while busy.
  - mthi and mtlo together write both registers.
  - Simultaneous start and mthi/mtlo in IDLE: both take effect. The write lands now; the multiply result overwrites it at E34.
- No arithmetic here; HI/LO are plain W-bit registers. cnt never wraps because it is cleared in LOAD.

Test Plan:
- Reset, then start with A=7, B=6. The bench uses a behavioural multiplier honouring the contract. Required: multCtrl high exactly during cycle E0..E1, busy high for 34 cycles, hi=0 and lo=42 at E34, done for one cycle.
- A=0xFFFFFFFD (-3), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 at E34. A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0.
- Extra start pulses at E5 and E20 during an operation -> ignored. mult_srcA/B unchanged, single done at E34, result of the first operands.
- IDLE: mthi with wr_data=0x12345678 -> hi=0x12345678 next edge. mtlo at E10 of a busy multiply -> lo unchanged until overwritten by the product at E34.
- Assert reset at E15 mid-multiply -> immediately busy=0, hi=lo=0, no done. A new start with 2*3 -> lo=6 at 34 cycles after the new start.
- start asserted in the done cycle -> second multiply accepted, second done exactly 35 cycles after the first done.
